// File: rtl/soc_system_pio_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_pio_arb_pkg
// Description : Shared types and default widths for the PIO arbiter slice.
//               Holds the arbiter FSM state encoding and the default
//               requester count / bus widths used by the interface and top.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_system_pio_arb_pkg;

    // Arbiter FSM: grant in IDLE, one slave cycle in ACCESS, one ack cycle.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } arb_state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 2;

endpackage
`default_nettype wire

// File: rtl/soc_system_pio_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_pio_arbiter_if
// Description : Bundles the requester-side handshake and the Avalon-MM PIO
//               slave signals seen by the arbiter.
//   Requester side : req, req_write, req_address, req_writedata (in)
//                    ack, rsp_readdata, busy (out)
//   Slave side     : avm_address, avm_chipselect, avm_write_n,
//                    avm_writedata (out), avm_readdata (in)
//   Modports       : master = arbiter view, slave = environment view
// Revision    : 1.0 - initial release
// ============================================================================
interface soc_system_pio_arbiter_if
    import soc_system_pio_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*DATA_W-1:0] req_writedata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rsp_readdata;
    logic                      busy;

    logic [ADDR_W-1:0]         avm_address;
    logic                      avm_chipselect;
    logic                      avm_write_n;
    logic [DATA_W-1:0]         avm_writedata;
    logic [DATA_W-1:0]         avm_readdata;

    modport master (
        input  req, req_write, req_address, req_writedata, avm_readdata,
        output ack, rsp_readdata, busy,
        output avm_address, avm_chipselect, avm_write_n, avm_writedata
    );

    modport slave (
        output req, req_write, req_address, req_writedata, avm_readdata,
        input  ack, rsp_readdata, busy,
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata
    );

endinterface
`default_nettype wire

// File: rtl/soc_system_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_rr_pick
// Description : Combinational round-robin picker. Searches req starting at
//               (last_grant_i + 1) mod NUM_REQ, wrapping, and returns the
//               first set bit as a one-hot grant plus its index.
//   req_i        : request vector
//   last_grant_i : index of the previous winner
//   grant_o      : one-hot winner (zero when no request)
//   grant_idx_o  : winner index
//   valid_o      : at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module soc_system_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] req_i,
    input  wire logic [IDX_W-1:0]   last_grant_i,
    output logic      [NUM_REQ-1:0] grant_o,
    output logic      [IDX_W-1:0]   grant_idx_o,
    output logic                    valid_o
);

    always_comb begin
        int w_cand;
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        w_cand      = 0;
        // Offsets 1..NUM_REQ: the previous winner is checked last, and the
        // modulo keeps the wrap correct for non-power-of-two counts.
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = (int'(last_grant_i) + i) % NUM_REQ;
            if (!valid_o && req_i[w_cand]) begin
                valid_o          = 1'b1;
                grant_o[w_cand]  = 1'b1;
                grant_idx_o      = IDX_W'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/soc_system_pio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_pio_arbiter
// Description : Round-robin arbiter sharing one zero-wait-state Avalon-MM
//               PIO slave among NUM_REQ requesters. Each grant performs one
//               single-word access (one chipselect cycle) followed by a
//               one-cycle ack pulse to the winner.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : soc_system_pio_arbiter_if.master (requester + slave signals)
// Revision    : 1.0 - initial release
// ============================================================================
module soc_system_pio_arbiter
    import soc_system_pio_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input wire logic                  clk,
    input wire logic                  reset,
    soc_system_pio_arbiter_if.master  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q,      state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] win_q,        win_d;
    logic [NUM_REQ-1:0] ack_q,        ack_d;
    logic [DATA_W-1:0]  rsp_q,        rsp_d;
    logic [DATA_W-1:0]  wdata_q,      wdata_d;
    logic [ADDR_W-1:0]  addr_q,       addr_d;
    logic               cs_q,         cs_d;
    logic               wn_q,         wn_d;

    logic [NUM_REQ-1:0] w_pick_oh;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_vld;

    soc_system_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i        (bus.req),
        .last_grant_i (last_grant_q),
        .grant_o      (w_pick_oh),
        .grant_idx_o  (w_pick_idx),
        .valid_o      (w_pick_vld)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            win_q        <= '0;
            ack_q        <= '0;
            rsp_q        <= '0;
            wdata_q      <= '0;
            addr_q       <= '0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            ack_q        <= ack_d;
            rsp_q        <= rsp_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        ack_d        = ack_q;
        rsp_d        = rsp_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        cs_d         = cs_q;
        wn_d         = wn_q;
        case (state_q)
            S_IDLE: begin
                // Payload is latched at grant so requesters may change their
                // lanes (or drop req) right after this edge.
                if (w_pick_vld) begin
                    addr_d       = bus.req_address[w_pick_idx*ADDR_W +: ADDR_W];
                    wdata_d      = bus.req_writedata[w_pick_idx*DATA_W +: DATA_W];
                    wn_d         = ~bus.req_write[w_pick_idx];
                    cs_d         = 1'b1;
                    last_grant_d = w_pick_idx;
                    win_d        = w_pick_oh;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Slave read data is combinational; capture it on the single
                // chipselect cycle. Writes leave the last read data in place.
                if (wn_q) begin
                    rsp_d = bus.avm_readdata;
                end
                cs_d    = 1'b0;
                wn_d    = 1'b1;
                ack_d   = win_q;
                state_d = S_ACK;
            end
            S_ACK: begin
                ack_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                ack_d   = '0;
                cs_d    = 1'b0;
                wn_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ack            = ack_q;
    assign bus.rsp_readdata   = rsp_q;
    assign bus.busy           = (state_q == S_ACCESS) || (state_q == S_ACK);
    assign bus.avm_address    = addr_q;
    assign bus.avm_chipselect = cs_q;
    assign bus.avm_write_n    = wn_q;
    assign bus.avm_writedata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_system_pio_arbiter
// Description : Self-checking bench for soc_system_pio_arbiter with a
//               four-word PIO slave model. Single transactions come from a
//               vector table; contention, fairness and reset-abort are
//               hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_system_pio_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    soc_system_pio_arbiter_if #(
        .NUM_REQ (NUM_REQ), .DATA_W (DATA_W), .ADDR_W (ADDR_W)
    ) bus ();

    soc_system_pio_arbiter #(
        .NUM_REQ (NUM_REQ), .DATA_W (DATA_W), .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Slave model: four registers, combinational read, write on chipselect.
    logic [DATA_W-1:0] slave_regs [4] = '{32'h0, 32'h0, 32'hCAFE_F00D, 32'h0};
    assign bus.avm_readdata = slave_regs[bus.avm_address];
    always @(posedge clk) begin
        if (bus.avm_chipselect && !bus.avm_write_n)
            slave_regs[bus.avm_address] <= bus.avm_writedata;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_req();
        bus.req           = '0;
        bus.req_write     = '0;
        bus.req_address   = '0;
        bus.req_writedata = '0;
    endtask

    task automatic set_lane(input int r, input bit wr, input logic [1:0] a, input logic [31:0] d);
        bus.req[r]                           = 1'b1;
        bus.req_write[r]                     = wr;
        bus.req_address[r*ADDR_W +: ADDR_W]  = a;
        bus.req_writedata[r*DATA_W +: DATA_W] = d;
    endtask

    function automatic int oh_idx(input logic [NUM_REQ-1:0] oh);
        int idx;
        idx = -1;
        for (int i = 0; i < NUM_REQ; i++) if (oh[i]) idx = i;
        return idx;
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    // One isolated access starting from IDLE; checks exact latency.
    task automatic do_txn(input int r, input bit wr, input logic [1:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rsp);
        @(negedge clk);
        set_lane(r, wr, a, d);
        @(negedge clk);
        chk($sformatf("txn%0d cs", r),      32'(bus.avm_chipselect), 32'd1);
        chk($sformatf("txn%0d write_n", r), 32'(bus.avm_write_n),    32'(!wr));
        chk($sformatf("txn%0d addr", r),    32'(bus.avm_address),    32'(a));
        if (wr) chk($sformatf("txn%0d wdata", r), bus.avm_writedata, d);
        chk($sformatf("txn%0d busy", r),    32'(bus.busy),           32'd1);
        // Drop req and scramble the lanes: payload must already be captured.
        bus.req[r] = 1'b0;
        bus.req_address[r*ADDR_W +: ADDR_W]   = ~a;
        bus.req_writedata[r*DATA_W +: DATA_W] = ~d;
        @(negedge clk);
        chk($sformatf("txn%0d ack", r),     32'(bus.ack),            32'(1 << r));
        chk($sformatf("txn%0d rsp", r),     bus.rsp_readdata,        exp_rsp);
        chk($sformatf("txn%0d cs off", r),  32'(bus.avm_chipselect), 32'd0);
        @(negedge clk);
        chk($sformatf("txn%0d ack off", r), 32'(bus.ack),            32'd0);
        chk($sformatf("txn%0d rsp held", r), bus.rsp_readdata,       exp_rsp);
        chk($sformatf("txn%0d idle", r),    32'(bus.busy),           32'd0);
        clear_req();
    endtask

    typedef struct {
        int          r;
        bit          wr;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int prev_cyc, n_acks, n0_before, idx;
        bit got3, cs_prev, seen;
        int exp_order [5];

        tbl[0] = '{2, 1'b1, 2'd0, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[1] = '{1, 1'b0, 2'd0, 32'h0,         32'hDEAD_BEEF};
        tbl[2] = '{0, 1'b1, 2'd1, 32'h1234_5678, 32'hDEAD_BEEF};
        tbl[3] = '{1, 1'b0, 2'd1, 32'h0,         32'h1234_5678};
        tbl[4] = '{3, 1'b1, 2'd3, 32'hA5A5_0F0F, 32'h1234_5678};
        tbl[5] = '{2, 1'b0, 2'd3, 32'h0,         32'hA5A5_0F0F};
        tbl[6] = '{3, 1'b0, 2'd2, 32'h0,         32'hCAFE_F00D};
        exp_order = '{0, 1, 2, 3, 0};

        // ---------------- reset values ----------------
        clear_req();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ack",     32'(bus.ack),            32'd0);
        chk("rst busy",    32'(bus.busy),           32'd0);
        chk("rst rsp",     bus.rsp_readdata,        32'd0);
        chk("rst cs",      32'(bus.avm_chipselect), 32'd0);
        chk("rst write_n", 32'(bus.avm_write_n),    32'd1);
        chk("rst addr",    32'(bus.avm_address),    32'd0);
        chk("rst wdata",   bus.avm_writedata,       32'd0);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle quiet", {30'd0, bus.avm_chipselect, bus.busy} | 32'(bus.ack), 32'd0);
        end

        // ---------------- table-driven single accesses ----------------
        for (int v = 0; v < 7; v++)
            do_txn(tbl[v].r, tbl[v].wr, tbl[v].a, tbl[v].d, tbl[v].exp_rsp);

        // ---------------- contention: all four held from reset ----------------
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) set_lane(r, 1'b0, 2'(r), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        n_acks = 0; prev_cyc = 0; cs_prev = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (cs_prev && bus.avm_chipselect) chk("cs double", 32'd1, 32'd0);
            cs_prev = bus.avm_chipselect;
            if (bus.ack != '0) begin
                chk("cont onehot", 32'($countones(bus.ack)), 32'd1);
                if (n_acks < 5) chk($sformatf("cont order%0d", n_acks),
                                    32'(oh_idx(bus.ack)), 32'(exp_order[n_acks]));
                if (n_acks > 0) chk("cont spacing", 32'(c - prev_cyc), 32'd3);
                prev_cyc = c;
                n_acks++;
            end
        end
        chk("cont ack count", 32'(n_acks), 32'd7);
        clear_req();

        // ---------------- fairness: req0 permanent, req3 pulsed ----------------
        do_reset(2);
        set_lane(0, 1'b0, 2'd0, 32'h0);
        got3 = 1'b0; n0_before = 0; seen = 1'b0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) set_lane(3, 1'b0, 2'd3, 32'h0);
            idx = oh_idx(bus.ack);
            if (got3 && idx == 0) seen = 1'b1;
            if (!got3 && idx == 0) n0_before++;
            if (idx == 3) begin
                got3 = 1'b1;
                bus.req[3] = 1'b0;
            end
        end
        chk("fair req3 served", 32'(got3),      32'd1);
        chk("fair req0 before", 32'(n0_before), 32'd1);
        chk("fair req0 resumes", 32'(seen),     32'd1);
        clear_req();

        // ---------------- reset during ACCESS ----------------
        do_reset(2);
        set_lane(2, 1'b0, 2'd2, 32'h0);
        set_lane(3, 1'b0, 2'd3, 32'h0);
        @(negedge clk);
        chk("abort pre cs",   32'(bus.avm_chipselect), 32'd1);
        chk("abort pre addr", 32'(bus.avm_address),    32'd2);
        reset = 1'b1;
        #1;
        chk("abort cs",      32'(bus.avm_chipselect), 32'd0);
        chk("abort write_n", 32'(bus.avm_write_n),    32'd1);
        chk("abort busy",    32'(bus.busy),           32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort no ack", 32'(bus.ack), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("reserve cs",   32'(bus.avm_chipselect), 32'd1);
        chk("reserve addr", 32'(bus.avm_address),    32'd2);
        @(negedge clk);
        chk("reserve ack",  32'(bus.ack),            32'b0100);
        clear_req();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
